// File: rtl/multiplicador_secuencial_pkg.sv
// Shared types and constants for the sequential signed shift-and-add multiplier.
package multiplicador_secuencial_pkg;

    localparam int unsigned DEFAULT_WORD_LENGTH = 6;
    localparam int unsigned STATE_WIDTH         = 2;

    localparam logic [STATE_WIDTH-1:0] IDLE_CODE = 2'd0;
    localparam logic [STATE_WIDTH-1:0] LOAD_CODE = 2'd1;
    localparam logic [STATE_WIDTH-1:0] MULT_CODE = 2'd2;
    localparam logic [STATE_WIDTH-1:0] DONE_CODE = 2'd3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE = IDLE_CODE,
        ST_LOAD = LOAD_CODE,
        ST_MULT = MULT_CODE,
        ST_DONE = DONE_CODE
    } state_t;

endpackage

// File: rtl/multiplicador_secuencial_if.sv
// Request/result bus between a requester and the sequential multiplier.
interface multiplicador_secuencial_if
    import multiplicador_secuencial_pkg::*;
#(
    parameter int unsigned Word_Length = DEFAULT_WORD_LENGTH
);
    logic                       Start_Input;
    logic [Word_Length-1:0]     Multiplicand_Input;
    logic [Word_Length-1:0]     Multiplier_Input;
    logic                       Ready_Output;
    logic [2*Word_Length-1:0]   Product_Output;

    modport master (
        output Start_Input,
        output Multiplicand_Input,
        output Multiplier_Input,
        input  Ready_Output,
        input  Product_Output
    );

    modport slave (
        input  Start_Input,
        input  Multiplicand_Input,
        input  Multiplier_Input,
        output Ready_Output,
        output Product_Output
    );
endinterface

// File: rtl/multiplicador_secuencial_ca2_converter.sv
// Conditional two's-complement negation; a zero input stays zero when negated.
module ca2_converter #(
    parameter int unsigned Width = 12
) (
    input  logic             negate,
    input  logic [Width-1:0] value,
    output logic [Width-1:0] result
);
    assign result = negate ? Width'(~value + Width'(1)) : value;
endmodule

// File: rtl/multiplicador_secuencial.sv
// Signed W x W multiplier: sign-magnitude shift-and-add over W cycles, then a
// conditional two's-complement fix-up of the magnitude product.
module multiplicador_secuencial
    import multiplicador_secuencial_pkg::*;
#(
    parameter int unsigned Word_Length = DEFAULT_WORD_LENGTH
) (
    input  logic                       Clk_Input,
    input  logic                       Reset_Input,
    multiplicador_secuencial_if.slave  bus,
    output logic                       Start_Output,
    output logic                       Load_Enable_output,
    output logic                       Enable_output,
    output logic [1:0]                 State_output,
    output logic [Word_Length-1:0]     count,
    output logic [2*Word_Length-1:0]   Multiplicand_Output,
    output logic [Word_Length-1:0]     Miltiplier_Output,
    output logic                       Sign_output,
    output logic                       Shift_CA2,
    output logic [2*Word_Length-1:0]   Left_Shifter_Multiplicand_output,
    output logic [Word_Length-1:0]     Right_Shifter_Multiplier_output,
    output logic [2*Word_Length-1:0]   Product_Output_MUXANDSUM,
    output logic [2*Word_Length-1:0]   Product_Converted_Output
);
    localparam int unsigned W  = Word_Length;
    localparam int unsigned PW = 2 * Word_Length;

    state_t          state, state_next;
    logic            load_c, mult_c, last_c;
    logic [W-1:0]    mag_a_c, mag_b_c;
    logic [PW-1:0]   sum_c;
    logic [PW-1:0]   mcand;
    logic [W-1:0]    mplier;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   product;
    logic            ready;
    logic            sign;

    // Next-state and per-state strobes.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        mult_c     = 1'b0;
        last_c     = 1'b0;
        case (state)
            ST_IDLE: if (bus.Start_Input) state_next = ST_LOAD;
            ST_LOAD: begin
                load_c     = 1'b1;
                state_next = ST_MULT;
            end
            ST_MULT: begin
                mult_c = 1'b1;
                if (count == W'(W - 1)) begin
                    last_c     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: if (!bus.Start_Input) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_Input or posedge Reset_Input) begin
        if (Reset_Input) state <= ST_IDLE;
        else             state <= state_next;
    end

    // Unsigned magnitudes; the most negative value maps onto 2^(W-1) without overflow.
    assign mag_a_c = bus.Multiplicand_Input[W-1] ? W'(~bus.Multiplicand_Input + W'(1))
                                                 : bus.Multiplicand_Input;
    assign mag_b_c = bus.Multiplier_Input[W-1]   ? W'(~bus.Multiplier_Input + W'(1))
                                                 : bus.Multiplier_Input;

    // Accumulator including this cycle's partial product, so the final edge sees the last add.
    assign sum_c = acc + (mplier[0] ? mcand : '0);

    ca2_converter #(
        .Width (PW)
    ) u_ca2 (
        .negate (sign),
        .value  (sum_c),
        .result (Product_Converted_Output)
    );

    always_ff @(posedge Clk_Input or posedge Reset_Input) begin
        if (Reset_Input) begin
            Start_Output       <= 1'b0;
            Load_Enable_output <= 1'b0;
            Enable_output      <= 1'b0;
            ready              <= 1'b0;
            mcand              <= '0;
            mplier             <= '0;
            sign               <= 1'b0;
            acc                <= '0;
            count              <= '0;
            product            <= '0;
        end else begin
            Start_Output       <= bus.Start_Input;
            Load_Enable_output <= (state_next == ST_LOAD);
            Enable_output      <= (state_next == ST_MULT);
            ready              <= (state_next == ST_DONE);
            if (load_c) begin
                mcand  <= PW'(mag_a_c);
                mplier <= mag_b_c;
                sign   <= bus.Multiplicand_Input[W-1] ^ bus.Multiplier_Input[W-1];
                acc    <= '0;
                count  <= '0;
            end
            if (mult_c) begin
                acc    <= sum_c;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + W'(1);
                if (last_c) product <= Product_Converted_Output;
            end
        end
    end

    assign bus.Ready_Output                 = ready;
    assign bus.Product_Output               = product;
    assign State_output                     = state;
    assign Multiplicand_Output              = mcand;
    assign Miltiplier_Output                = mplier;
    assign Sign_output                      = sign;
    assign Shift_CA2                        = sign & last_c;
    assign Left_Shifter_Multiplicand_output = mcand << 1;
    assign Right_Shifter_Multiplier_output  = mplier >> 1;
    assign Product_Output_MUXANDSUM         = acc;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: directed vectors, timing
// sequences, reset abort and a full operand sweep.
module tb_multiplicador_secuencial;
    import multiplicador_secuencial_pkg::*;

    localparam int unsigned W  = 6;
    localparam int unsigned PW = 12;

    typedef struct {
        int a;
        int b;
        int p;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplicador_secuencial_if #(.Word_Length(W)) bus ();

    logic            start_out, load_en, en, sign_o, shift_ca2;
    logic [1:0]      state_o;
    logic [W-1:0]    count_o, mplier_o, rshift_o;
    logic [PW-1:0]   mcand_o, lshift_o, acc_o, conv_o;

    multiplicador_secuencial #(.Word_Length(W)) dut (
        .Clk_Input                        (clk),
        .Reset_Input                      (rst),
        .bus                              (bus),
        .Start_Output                     (start_out),
        .Load_Enable_output               (load_en),
        .Enable_output                    (en),
        .State_output                     (state_o),
        .count                            (count_o),
        .Multiplicand_Output              (mcand_o),
        .Miltiplier_Output                (mplier_o),
        .Sign_output                      (sign_o),
        .Shift_CA2                        (shift_ca2),
        .Left_Shifter_Multiplicand_output (lshift_o),
        .Right_Shifter_Multiplier_output  (rshift_o),
        .Product_Output_MUXANDSUM         (acc_o),
        .Product_Converted_Output         (conv_o)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int prod_s();
        return int'($signed(bus.Product_Output));
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.Ready_Output) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One full transaction: expected pushed at request, popped at Ready.
    task automatic run_op(input int a, input int b, input int exp, input string name);
        bit ok;
        int e;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.Multiplicand_Input = W'(a);
        bus.Multiplier_Input   = W'(b);
        bus.Start_Input        = 1'b1;
        wait_ready(ok);
        e = exp_q.pop_front();
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: ready timeout, got ready=0 want ready=1 (a=%0d b=%0d)", name, a, b);
        end else begin
            check(name, prod_s(), e);
        end
        bus.Start_Input = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{3,   -5,  -15};
        vecs[1]  = '{-32, -32, 1024};
        vecs[2]  = '{31,  -32, -992};
        vecs[3]  = '{-32, 31,  -992};
        vecs[4]  = '{0,   -17, 0};
        vecs[5]  = '{-1,  -1,  1};
        vecs[6]  = '{7,   7,   49};
        vecs[7]  = '{-7,  9,   -63};
        vecs[8]  = '{31,  31,  961};
        vecs[9]  = '{-32, 1,   -32};
        vecs[10] = '{1,   -32, -32};
        vecs[11] = '{-17, 0,   0};
        vecs[12] = '{0,   0,   0};

        rst                    = 1'b1;
        bus.Start_Input        = 1'b0;
        bus.Multiplicand_Input = '0;
        bus.Multiplier_Input   = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state",   int'(state_o), 0);
        check("reset_product", prod_s(), 0);
        check("reset_ready",   int'(bus.Ready_Output), 0);
        check("reset_count",   int'(count_o), 0);
        check("reset_acc",     int'(acc_o), 0);
        rst = 1'b0;

        // Latency, operand isolation and result hold for 3 x -5.
        @(negedge clk);
        exp_q.push_back(-15);
        bus.Multiplicand_Input = W'(3);
        bus.Multiplier_Input   = W'(-5);
        bus.Start_Input        = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) check("load_enable", int'(load_en), 1);
            if (k == 2) begin
                check("mult_enable", int'(en), 1);
                bus.Multiplicand_Input = W'(31);
                bus.Multiplier_Input   = W'(31);
            end
            check("latency_not_ready", int'(bus.Ready_Output), 0);
            check("product_hold_busy", prod_s(), 0);
        end
        @(negedge clk);
        check("latency_ready", int'(bus.Ready_Output), 1);
        check("latency_product", prod_s(), exp_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_hold_state", int'(state_o), 3);
        end
        bus.Start_Input = 1'b0;
        @(negedge clk);
        check("idle_after_done", int'(state_o), 0);
        check("idle_ready_low",  int'(bus.Ready_Output), 0);
        check("idle_product_hold", prod_s(), -15);

        // Reset in the middle of MULT aborts the operation.
        @(negedge clk);
        bus.Multiplicand_Input = W'(5);
        bus.Multiplier_Input   = W'(-9);
        bus.Start_Input        = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("pre_abort_state", int'(state_o), 2);
        rst             = 1'b1;
        bus.Start_Input = 1'b0;
        #1;
        check("abort_state",   int'(state_o), 0);
        check("abort_product", prod_s(), 0);
        check("abort_ready",   int'(bus.Ready_Output), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(7, 7, 49, "after_abort");

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, "vector");

        for (int i = -32; i < 32; i++)
            for (int j = -32; j < 32; j++)
                run_op(i, j, i * j, "sweep");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
